clk_en_sched: RTL and testbench
===============================

Name: clk_en_sched

Overview:
Programmable clock-enable scheduler for the FemtoRV32 pipeline. It produces a one-cycle `tick` enable and a divided clock `Q` from the system clock. The processor clock can run free, halt, or single-step N divided periods, which serves debug and board bring-up. Divisor and mode are reconfigured through a valid/ready handshake, and new settings take effect only on a period boundary, so `Q` and `tick` never glitch.

Parameters:
DIV_W, 16, width of divisor
CNT_W, 16, width of step counter
DEF_DIV, 2, divisor after reset (must be >=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
cfg_valid  in  1  config request
cfg_ready  out  1  scheduler can accept config
cfg_mode  in  2  00 HALT, 01 RUN, 10 STEP, 11 reserved (=HALT)
cfg_div  in  DIV_W  new divisor D; 0 treated as 1
cfg_steps  in  CNT_W  tick count for STEP
tick  out  1  registered one-cycle enable pulse per divided period
Q  out  1  divided clock, toggles on every tick (period 2*D)
busy  out  1  state is RUN or STEP
cur_div  out  DIV_W  divisor currently applied
steps_left  out  CNT_W  remaining STEP ticks
done  out  1  one-cycle pulse when STEP completes

Behaviour:
- Reset (rst=0, async): state HALT, internal counter cnt=0, tick=0, Q=0, cfg_ready=1, busy=0, cur_div=DEF_DIV, steps_left=0, done=0. Any pending config is discarded.
- Handshake: a config is accepted on a clock edge with cfg_valid&&cfg_ready. The accepted mode/div/steps are latched as pending, and cfg_ready drops to 0 on the next cycle.
  - cfg_ready returns to 1 the cycle after the pending config is applied.
  - Only one config may be pending at a time.
- Apply point:
  - In HALT, a pending config is applied on the edge after acceptance.
  - In RUN/STEP, it is applied on the edge that emits a tick (period boundary).
  - A config accepted in the same cycle as a boundary waits for the next boundary.
  - On apply: cur_div <= max(cfg_div,1), cnt <= 0, state <= mode, steps_left <= cfg_steps when mode is STEP, else unchanged.
- Counting:
  - In RUN/STEP, cnt increments each cycle. When cnt==cur_div-1, cnt wraps to 0, and on that edge tick<=1 and Q<=~Q.
  - tick is 0 on all other cycles.
  - First tick arrives cur_div cycles after apply. With D=1, tick is high every cycle.
- HALT: cnt, Q and steps_left hold; tick=0; busy=0.
- STEP:
  - Each tick decrements steps_left.
  - The tick with steps_left==1 moves the state to HALT; done=1 on the cycle after that tick.
  - STEP with cfg_steps=0: enters HALT at apply, done pulses once, no tick.
- Reserved mode 11 behaves exactly as HALT.
- cur_div changes only at apply, so there is no mid-period divisor change.

Optional Feature:
Macro CLK_SCHED_TICKCNT_EN.
- Defined: adds output port tick_cnt (out, 32), a free-running count of emitted ticks. It is cleared by reset, increments on each tick, and wraps from 0xFFFFFFFF to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 10ns, then release -> tick=0, Q=0, cfg_ready=1, busy=0, cur_div=2, state HALT.
- RUN D=4 from HALT -> tick pulses every 4 cycles, first pulse 4 cycles after apply; Q toggles on each pulse (period 8 cycles); busy=1.
- STEP D=3 steps=5 -> exactly 5 ticks spaced 3 cycles apart; steps_left counts 5..0; done pulses once, 1 cycle after the 5th tick; busy=0 afterwards; Q holds.
- While RUN D=8 at cnt=2, send RUN D=2 -> cfg_ready=0 until the next tick; the new 2-cycle spacing starts from that boundary; no short pulse or glitch on Q.
- Edge cases: cfg_div=0 -> behaves as D=1 (tick every cycle); STEP steps=0 -> done pulse, no tick; mode 11 -> HALT.
- Assert rst=0 mid-STEP with a config pending -> all outputs return to reset values immediately; the pending config is not applied after release.

Source files
------------

// File: rtl/clk_en_sched.sv
// Programmable clock-enable scheduler: free-run / halt / single-step tick and divided clock Q.
// Optional macro CLK_SCHED_TICKCNT_EN adds a 32-bit free-running tick counter output (tick_cnt).
module clk_en_sched #(
    parameter int DIV_W   = 16,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_steps,
    output logic             tick,
    output logic             Q,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div,
    output logic [CNT_W-1:0] steps_left,
    output logic             done,
    output logic [1:0]       dbg_state
`ifdef CLK_SCHED_TICKCNT_EN
    ,
    output logic [31:0]      tick_cnt
`endif
);

    // Debug encoding on dbg_state: 0 HALT, 1 RUN, 2 STEP.
    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [1:0] M_RUN  = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] cnt;
    logic             pend;
    logic [1:0]       pend_mode;
    logic [DIV_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_steps;
    logic             fin;

    logic             accept;
    logic             boundary;
    logic             last_step;
    logic             apply;
    logic             step_zero;

    // Handshake: accept on cfg_valid && cfg_ready; cfg_ready is low while a config is pending.
    assign accept    = cfg_valid && cfg_ready;
    assign boundary  = (state != S_HALT) && (cnt == cur_div - DIV_W'(1));
    assign last_step = boundary && (state == S_STEP) && (steps_left == CNT_W'(1));
    assign apply     = pend && ((state == S_HALT) || boundary);
    assign step_zero = (pend_mode == M_STEP) && (pend_steps == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_HALT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (last_step) begin
            state_nxt = S_HALT;
        end
        // A config applied on the final STEP tick overrides the fall back to HALT.
        if (apply) begin
            case (pend_mode)
                M_RUN:   state_nxt = S_RUN;
                M_STEP:  state_nxt = step_zero ? S_HALT : S_STEP;
                default: state_nxt = S_HALT;
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_HALT);
        cfg_ready = !pend;
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            tick       <= 1'b0;
            Q          <= 1'b0;
            cur_div    <= DIV_W'(DEF_DIV);
            steps_left <= '0;
            done       <= 1'b0;
            fin        <= 1'b0;
            pend       <= 1'b0;
            pend_mode  <= '0;
            pend_div   <= '0;
            pend_steps <= '0;
        end else begin
            tick <= boundary;
            // done trails the completing tick by one cycle.
            fin  <= last_step || (apply && step_zero);
            done <= fin;
            if (boundary) begin
                Q <= ~Q;
            end
            if (state != S_HALT) begin
                cnt <= boundary ? '0 : cnt + DIV_W'(1);
            end
            if (boundary && (state == S_STEP)) begin
                steps_left <= steps_left - CNT_W'(1);
            end
            if (accept) begin
                pend       <= 1'b1;
                pend_mode  <= cfg_mode;
                pend_div   <= cfg_div;
                pend_steps <= cfg_steps;
            end
            if (apply) begin
                pend    <= 1'b0;
                cnt     <= '0;
                cur_div <= (pend_div == '0) ? DIV_W'(1) : pend_div;
                if (pend_mode == M_STEP) begin
                    steps_left <= pend_steps;
                end
            end
        end
    end

`ifdef CLK_SCHED_TICKCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (boundary) begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clk_en_sched.sv
// Bench for clk_en_sched: directed scenarios plus random configs against an edge-indexed model.
module tb_clk_en_sched;

    localparam int DIV_W = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_mode;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_steps;
    logic             tick;
    logic             Q;
    logic             busy;
    logic [DIV_W-1:0] cur_div;
    logic [CNT_W-1:0] steps_left;
    logic             done;
    logic [1:0]       dbg_state;
`ifdef CLK_SCHED_TICKCNT_EN
    logic [31:0]      tick_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    clk_en_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DEF_DIV(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_div    (cfg_div),
        .cfg_steps  (cfg_steps),
        .tick       (tick),
        .Q          (Q),
        .busy       (busy),
        .cur_div    (cur_div),
        .steps_left (steps_left),
        .done       (done),
        .dbg_state  (dbg_state)
`ifdef CLK_SCHED_TICKCNT_EN
        ,
        .tick_cnt   (tick_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: a running scheduler ticks on every edge that is a multiple of the divisor
    // past the edge where its config was applied.
    int m_n, m_apply, m_state, m_div, m_steps, m_q, m_ticks;
    int m_pend, p_mode, p_div, p_steps, m_fin, e_tick, e_done, m_acc;

    task automatic model_reset();
        m_n = 0; m_apply = 0; m_state = 0; m_div = 2; m_steps = 0; m_q = 0; m_ticks = 0;
        m_pend = 0; p_mode = 0; p_div = 0; p_steps = 0; m_fin = 0; e_tick = 0; e_done = 0;
        m_acc = 0;
    endtask

    task automatic model_edge(input int v, input int md, input int d, input int s);
        int bnd, new_fin, old_state, old_pend;
        m_n++;
        old_state = m_state;
        old_pend  = m_pend;
        new_fin   = 0;
        bnd = (m_state != 0) && (((m_n - m_apply) % m_div) == 0);
        if (bnd) begin
            m_q = 1 - m_q;
            m_ticks++;
            if (m_state == 2) begin
                m_steps--;
                if (m_steps == 0) begin
                    m_state = 0;
                    new_fin = 1;
                end
            end
        end
        if (old_pend != 0 && (old_state == 0 || bnd != 0)) begin
            m_pend  = 0;
            m_div   = (p_div == 0) ? 1 : p_div;
            m_apply = m_n;
            if (p_mode == 1) m_state = 1;
            else if (p_mode == 2) begin
                m_steps = p_steps;
                if (p_steps == 0) begin
                    m_state = 0;
                    new_fin = 1;
                end else m_state = 2;
            end else m_state = 0;
        end
        m_acc = 0;
        if (v != 0 && old_pend == 0) begin
            m_pend = 1; p_mode = md; p_div = d; p_steps = s; m_acc = 1;
        end
        e_tick = bnd;
        e_done = m_fin;
        m_fin  = new_fin;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tick", 32'(tick), 32'(e_tick));
        chk("q", 32'(Q), 32'(m_q));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_pend == 0));
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("cur_div", 32'(cur_div), 32'(m_div));
        chk("steps_left", 32'(steps_left), 32'(m_steps));
        chk("done", 32'(done), 32'(e_done));
        chk("state", 32'(dbg_state), 32'(m_state));
`ifdef CLK_SCHED_TICKCNT_EN
        chk("tick_cnt", tick_cnt, 32'(m_ticks));
`endif
    endtask

    task automatic cyc(input logic v, input logic [1:0] md, input int d, input int s);
        cfg_valid = v;
        cfg_mode  = md;
        cfg_div   = DIV_W'(d);
        cfg_steps = CNT_W'(s);
        @(posedge clk);
        model_edge(int'(v), int'(md), d, s);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 0, 0);
    endtask

    // Holds cfg_valid until the request is taken; divisors stay small so 64 edges always suffice.
    task automatic send(input logic [1:0] md, input int d, input int s);
        int k;
        k = 0;
        m_acc = 0;
        while (m_acc == 0 && k < 64) begin
            cyc(1'b1, md, d, s);
            k++;
        end
    endtask

    initial begin
        int nt, nd;
        rst = 1'b0; cfg_valid = 1'b0; cfg_mode = '0; cfg_div = '0; cfg_steps = '0;
        model_reset();
        #12;
        rst = 1'b1;
        #1;
        check_all();

        // Free run D=4 from HALT.
        send(2'b01, 4, 0);
        idle(20);

        // Return to HALT at a boundary, then STEP D=3 x5.
        send(2'b00, 4, 0);
        idle(3);
        send(2'b10, 3, 5);
        nt = 0; nd = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 2'b00, 0, 0);
            nt += int'(tick);
            nd += int'(done);
        end
        chk("step_tick_count", 32'(nt), 32'd5);
        chk("step_done_count", 32'(nd), 32'd1);

        // Divisor change mid-period waits for the next boundary.
        send(2'b01, 8, 0);
        idle(2);
        send(2'b01, 2, 0);
        idle(16);

        // Divisor 0 runs as 1, STEP with zero steps, reserved mode halts.
        send(2'b01, 0, 0);
        idle(6);
        send(2'b10, 1, 0);
        idle(4);
        send(2'b01, 3, 0);
        idle(5);
        send(2'b11, 5, 7);
        idle(8);

        for (int r = 0; r < 40; r++) begin
            send(2'($urandom_range(0, 3)), $urandom_range(0, 6), $urandom_range(0, 4));
            idle($urandom_range(0, 12));
        end

        // Reset mid-STEP with a config pending.
        send(2'b00, 1, 0);
        idle(2);
        send(2'b10, 8, 3);
        idle(3);
        send(2'b01, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
